// File: rtl/shift_scroll_reg_pkg.sv
// Shared encodings for the shift/scroll register: step operations and burst FSM states.
package shift_scroll_reg_pkg;

    typedef enum logic [2:0] {
        ModeHold = 3'd0,
        ModeShr  = 3'd1,
        ModeShl  = 3'd2,
        ModeLoad = 3'd3,
        ModeRor  = 3'd4,
        ModeRol  = 3'd5,
        ModeAsr  = 3'd6,
        ModeRsvd = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Only modes that actually move bits make sense as a counted burst.
    function automatic logic is_burst_mode(mode_e m);
        return m inside {ModeShr, ModeShl, ModeRor, ModeRol, ModeAsr};
    endfunction

endpackage

// File: rtl/shift_scroll_reg_step_unit.sv
// Combinational next-value logic for one STEP-bit shift/rotate/load operation.
module shift_scroll_reg_step_unit
    import shift_scroll_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  mode_e              op,
    input  logic [WIDTH-1:0]   q,
    input  logic [STEP-1:0]    sl,
    input  logic [STEP-1:0]    sr,
    input  logic [WIDTH-1:0]   pdata,
    output logic [WIDTH-1:0]   q_next
);

    always_comb begin
        q_next = q;
        case (op)
            ModeShr:  q_next = {sr, q[WIDTH-1:STEP]};
            ModeShl:  q_next = {q[WIDTH-STEP-1:0], sl};
            ModeLoad: q_next = pdata;
            ModeRor:  q_next = {q[STEP-1:0], q[WIDTH-1:STEP]};
            ModeRol:  q_next = {q[WIDTH-STEP-1:0], q[WIDTH-1:WIDTH-STEP]};
            ModeAsr:  q_next = {{STEP{q[WIDTH-1]}}, q[WIDTH-1:STEP]};
            default:  q_next = q;
        endcase
    end

endmodule

// File: rtl/shift_scroll_reg.sv
// Universal shift/rotate register with a counted burst sequencer paced by ce.
module shift_scroll_reg
    import shift_scroll_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    parameter int unsigned CNT_W = 6
) (
    input  logic              clk,
    input  logic              CR,
    input  logic              ce,
    input  logic [2:0]        mode,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    input  logic              abort,
    input  logic [STEP-1:0]   SL,
    input  logic [STEP-1:0]   SR,
    input  logic [WIDTH-1:0]  PData,
    output logic [WIDTH-1:0]  Q,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    mode_e             bmode_q, bmode_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  q_q, q_d, q_step;
    mode_e             step_op;
    mode_e             mode_in;
    logic              busy_q, done_q;

    assign mode_in = mode_e'(mode);
    // During a burst the latched mode drives the datapath; live mode is ignored.
    assign step_op = (state_q == StRun) ? bmode_q : mode_in;

    shift_scroll_reg_step_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .op     (step_op),
        .q      (q_q),
        .sl     (SL),
        .sr     (SR),
        .pdata  (PData),
        .q_next (q_step)
    );

    always_comb begin
        state_d = state_q;
        bmode_d = bmode_q;
        rem_d   = rem_q;
        q_d     = q_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    bmode_d = mode_in;
                    rem_d   = count;
                    state_d = (count == '0 || !is_burst_mode(mode_in)) ? StDone : StRun;
                end else if (ce) begin
                    q_d = q_step;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (ce) begin
                    q_d   = q_step;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge CR) begin
        if (!CR) begin
            state_q <= StIdle;
            bmode_q <= ModeHold;
            rem_q   <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bmode_q <= bmode_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StDone);
        end
    end

    assign Q    = q_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shift_scroll_reg.sv
// Directed and randomized checks of shift_scroll_reg against a behavioural model.
module tb_shift_scroll_reg;

    localparam int W = 32;
    localparam int S = 4;
    localparam int C = 6;

    logic          clk = 1'b0;
    logic          CR = 1'b1;
    logic          ce = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic          start = 1'b0;
    logic [C-1:0]  count = '0;
    logic          abort = 1'b0;
    logic [S-1:0]  SL = '0;
    logic [S-1:0]  SR = '0;
    logic [W-1:0]  PData = '0;
    logic [W-1:0]  Q;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    // Model state: register value, whether a burst is active, steps left, pending done.
    logic [W-1:0]  m_q = '0;
    bit            m_run = 0;
    bit            m_done = 0;
    int            m_left = 0;
    logic [2:0]    m_bmode = 3'd0;

    shift_scroll_reg #(.WIDTH(W), .STEP(S), .CNT_W(C)) dut (
        .clk   (clk),
        .CR    (CR),
        .ce    (ce),
        .mode  (mode),
        .start (start),
        .count (count),
        .abort (abort),
        .SL    (SL),
        .SR    (SR),
        .PData (PData),
        .Q     (Q),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] m_apply(logic [2:0] op, logic [W-1:0] q);
        logic [2*W-1:0] dbl;
        dbl = {q, q};
        case (op)
            3'd1: return (q >> S) | (W'(SR) << (W - S));
            3'd2: return (q << S) | W'(SL);
            3'd3: return PData;
            3'd4: return dbl[W-1+S -: W];
            3'd5: return dbl[2*W-1-S -: W];
            3'd6: return W'($signed(q) >>> S);
            default: return q;
        endcase
    endfunction

    task automatic model_tick();
        if (m_done) begin
            m_done = 0;
        end else if (m_run) begin
            if (abort) begin
                m_run = 0;
            end else if (ce) begin
                m_q = m_apply(m_bmode, m_q);
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
        end else if (start) begin
            if (count == 0 || !(mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
                m_done = 1;
            end else begin
                m_run = 1;
                m_left = int'(count);
                m_bmode = mode;
            end
        end else if (ce) begin
            m_q = m_apply(mode, m_q);
        end
    endtask

    task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: model follows the edge, then DUT outputs are compared 1 time unit later.
    task automatic step(string tag);
        @(posedge clk);
        model_tick();
        #1;
        chk({tag, "_q"}, Q, m_q);
        chk({tag, "_busy"}, W'(busy), W'(m_run));
        chk({tag, "_done"}, W'(done), W'(m_done));
    endtask

    task automatic quiet();
        ce = 0; start = 0; abort = 0; mode = 3'd0; count = '0;
    endtask

    task automatic do_reset();
        CR = 1'b0;
        m_q = '0; m_run = 0; m_done = 0; m_left = 0;
        #1;
        chk("rst_q", Q, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        @(negedge clk);
        CR = 1'b1;
    endtask

    task automatic load(logic [W-1:0] v);
        quiet(); ce = 1; mode = 3'd3; PData = v;
        step("load");
        quiet();
    endtask

    initial begin
        #2;
        // 1: initial reset, then nothing moves without ce
        do_reset();
        #1 quiet(); mode = 3'd3; PData = 32'hDEADBEEF;
        step("t1_noce");
        chk("t1_hold0", Q, 32'h0);

        // 2: load then SHL, then ce=0 holds
        load(32'h12345678);
        chk("t2_load", Q, 32'h12345678);
        ce = 1; mode = 3'd2; SL = 4'hA;
        step("t2_shl");
        chk("t2_shl_c", Q, 32'h2345678A);
        ce = 0;
        for (int m = 1; m < 8; m++) begin
            mode = 3'(m);
            step("t2_hold");
        end
        chk("t2_hold_c", Q, 32'h2345678A);

        // 3: paced ROR burst of 3
        load(32'h12345678);
        start = 1; mode = 3'd4; count = 6'd3;
        step("t3_start");
        chk("t3_start_q", Q, 32'h12345678);
        start = 0; mode = 3'd3; PData = 32'hFFFFFFFF;
        begin
            logic [W-1:0] exp3 [3];
            exp3[0] = 32'h81234567; exp3[1] = 32'h78123456; exp3[2] = 32'h67812345;
            for (int k = 0; k < 3; k++) begin
                ce = 0;
                for (int g = 0; g < 3; g++) begin
                    step("t3_gap");
                    chk("t3_busy_gap", W'(busy), 32'h1);
                end
                ce = 1;
                step("t3_step");
                chk("t3_step_q", Q, exp3[k]);
            end
        end
        chk("t3_done", W'(done), 32'h1);
        quiet();
        step("t3_after");
        chk("t3_done_clr", W'(done), 32'h0);

        // 4: zero-length burst and LOAD burst finish immediately
        start = 1; mode = 3'd4; count = 6'd0; ce = 1;
        step("t4_zero");
        chk("t4_zero_done", W'(done), 32'h1);
        quiet();
        step("t4_zero_idle");
        start = 1; mode = 3'd3; count = 6'd5; ce = 1; PData = 32'hCAFEF00D;
        step("t4_load");
        chk("t4_load_q", Q, 32'h67812345);
        quiet();
        step("t4_load_idle");

        // 5: ROL burst aborted after two steps, then a new burst
        load(32'h12345678);
        start = 1; mode = 3'd5; count = 6'd5;
        step("t5_start");
        start = 0; ce = 1;
        step("t5_s1");
        step("t5_s2");
        abort = 1;
        step("t5_abort");
        chk("t5_abort_q", Q, 32'h34567812);
        chk("t5_abort_busy", W'(busy), 32'h0);
        abort = 0; ce = 0;
        step("t5_nodone");
        start = 1; mode = 3'd5; count = 6'd1;
        step("t5_restart");
        start = 0; ce = 1;
        step("t5_r1");
        chk("t5_r1_q", Q, 32'h45678123);
        quiet();
        step("t5_end");

        // 6: ASR sign fill, SHR serial in, start ignored while running
        load(32'h80000000);
        ce = 1; mode = 3'd6;
        step("t6_asr");
        chk("t6_asr_q", Q, 32'hF8000000);
        load(32'h80000000);
        ce = 1; mode = 3'd1; SR = 4'h5;
        step("t6_shr");
        chk("t6_shr_q", Q, 32'h58000000);
        load(32'h00000001);
        start = 1; mode = 3'd2; count = 6'd3; SL = 4'h0;
        step("t6_start");
        ce = 1; count = 6'd10;
        step("t6_s1");
        start = 0;
        step("t6_s2");
        step("t6_s3");
        chk("t6_q", Q, 32'h00001000);
        chk("t6_done", W'(done), 32'h1);
        quiet();
        step("t6_end");

        // Reset in the middle of a burst
        start = 1; mode = 3'd4; count = 6'd20; ce = 1;
        step("rb_start");
        start = 0;
        step("rb_s1");
        #2;
        do_reset();
        #1 quiet();
        step("rb_after");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ce    = ($urandom_range(0, 1) == 1);
            mode  = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 7) == 0);
            count = C'($urandom_range(0, 7));
            abort = ($urandom_range(0, 15) == 0);
            SL    = S'($urandom);
            SR    = S'($urandom);
            PData = $urandom;
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
